// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit for the EX stage.
// It owns the architectural HI/LO registers. Each operation takes WIDTH
// cycles: radix-2 shift-add multiply or restoring divide. While an operation
// is in flight, busy is high so the hazard logic can stall dependent work.
// Optional build macro: MDU_DIV0_FLAG_EN adds a div0 flag that pulses
// together with done for a divide by zero. Without it, div0 is tied low.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q;

    // Operation context captured at start; data only, so no reset.
    logic                 is_div_q;
    logic                 sa_q, sb_q;
    logic [WIDTH-1:0]     opd_q;     // |a| for multiply, |b| (divisor) for divide
    logic [WIDTH-1:0]     a_orig_q;  // untouched dividend, needed for HI on divide by zero
    logic [2*WIDTH-1:0]   acc_q;     // {partial, multiplier} or {remainder, quotient}

    logic                 fire;
    logic                 finish;
    logic                 last;
    logic                 sa_in, sb_in;
    logic [WIDTH-1:0]     mag_a, mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   div_nxt;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic                 div_by_zero;
    logic [WIDTH-1:0]     res_hi, res_lo;

    // Two's complement negation of one word.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] xs;
        xs = $signed(x);
        return $unsigned(-xs);
    endfunction

    // Two's complement negation of a double-width product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        logic signed [2*WIDTH-1:0] xs;
        xs = $signed(x);
        return $unsigned(-xs);
    endfunction

    assign busy = (state_q == RUN);
    assign last = (count_q == CNT_W'(WIDTH - 1));

    // Operand sign capture and magnitude for the signed ops (op[0]==0).
    always_comb begin
        sa_in = ~op[0] & a[WIDTH-1];
        sb_in = ~op[0] & b[WIDTH-1];
        mag_a = sa_in ? neg_w(a) : a;
        mag_b = sb_in ? neg_w(b) : b;
    end

    // One iteration of each datapath and the sign-corrected final result.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
        mul_nxt = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};

        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, opd_q};
        div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

        acc_nxt = is_div_q ? div_nxt : mul_nxt;

        div_by_zero = is_div_q && (opd_q == '0);

        if (!is_div_q) begin
            {res_hi, res_lo} = (sa_q ^ sb_q) ? neg_2w(acc_nxt) : acc_nxt;
        end else if (div_by_zero) begin
            res_hi = a_orig_q;
            res_lo = '1;
        end else begin
            res_lo = (sa_q ^ sb_q) ? neg_w(acc_nxt[WIDTH-1:0]) : acc_nxt[WIDTH-1:0];
            res_hi = sa_q ? neg_w(acc_nxt[2*WIDTH-1:WIDTH]) : acc_nxt[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic: flush always returns to IDLE and beats the final write.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = RUN;
                    fire    = 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, iteration counter and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= finish;
            if (fire) begin
                count_q <= '0;
            end else if (state_q == RUN) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Operand capture on start, then one accumulator step per RUN cycle.
    always_ff @(posedge clk) begin
        if (fire) begin
            is_div_q <= op[1];
            sa_q     <= sa_in;
            sb_q     <= sb_in;
            a_orig_q <= a;
            opd_q    <= op[1] ? mag_b : mag_a;
            acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
        end else if (state_q == RUN) begin
            acc_q    <= acc_nxt;
        end
    end

    // HI/LO: the result write wins; mthi/mtlo are honoured only in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state_q == IDLE) begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    // Divide-by-zero flag, aligned with the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div0 <= 1'b0;
        end else begin
            div0 <= finish && div_by_zero;
        end
    end
`else
    assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: hand-computed multiply/divide results,
// latency, done/div0 pulses, start-while-busy, flush and mid-op reset.
module tb_mdu_iterative;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] wd;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mdu_iterative #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wd      (wd),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .div0    (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue one operation and check latency, done/div0 and HI/LO.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit dbl_start);
        int n;
        logic exp_div0;
`ifdef MDU_DIV0_FLAG_EN
        exp_div0 = o[1] && (y == 32'h0);
`else
        exp_div0 = 1'b0;
`endif
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 32'h0; b = 32'h0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (dbl_start && n == 5) begin
                start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(n), 64'd32);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " div0"}, 64'(div0), 64'(exp_div0));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check({tag, " done drop"}, 64'(done), 64'd0);
        check({tag, " div0 drop"}, 64'(div0), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wd = 32'h0;

        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst div0", 64'(div0), 64'd0);
        check("rst hi",   64'(hi),   64'd0);
        check("rst lo",   64'(lo),   64'd0);
        reset_n = 1'b1;

        run_op("mult 7*-3",     2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("multu ffff*2",  2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b1);
        run_op("mult min*min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_op("div -7/2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div 7/-2",      2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("divu 100/7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_op("div ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu x/0",      2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b0);
        run_op("div -5/0",      2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);

        // mthi preload, then a flushed multiply must leave HI/LO alone;
        // an mthi attempted during RUN is ignored.
        @(negedge clk);
        hi_we = 1'b1; wd = 32'hAAAA0000;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", 64'(hi), 64'hAAAA0000);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b1; wd = 32'h55555555;
        check("flush busy run", 64'(busy), 64'd1);
        repeat (8) begin
            @(negedge clk);
            hi_we = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hi",   64'(hi),   64'hAAAA0000);
        check("flush lo",   64'(lo),   64'hFFFFFFFF);
        @(negedge clk);
        check("flush done later", 64'(done), 64'd0);

        // Reset mid-operation clears everything at once.
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst done", 64'(done), 64'd0);
        check("mid rst hi",   64'(hi),   64'd0);
        check("mid rst lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post rst hi", 64'(hi), 64'd0);

        // mtlo in IDLE.
        lo_we = 1'b1; wd = 32'h12345678;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'h12345678);
        check("mtlo hi kept", 64'(hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
